// File: rtl/axil_sched_pkg.sv
// Shared types and default constants for the AXI-Lite read/write scheduler.
package axil_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4
  } sched_state_e;

  typedef enum logic {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_e;

  localparam int unsigned HOLD_MAX_DEF       = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/axil_sched_watchdog.sv
// Completion watchdog: counts cycles while run is high, flags expiry on the
// TIMEOUT_CYCLES-th cycle. Only instantiated when AXIL_SCHED_TIMEOUT_EN is defined.
module axil_sched_watchdog
  import axil_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign expired = run && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/axil_rw_scheduler.sv
// Serialises write and read AXI-Lite beats with round-robin plus a tenure beat cap.
// Optional completion watchdog enabled by defining AXIL_SCHED_TIMEOUT_EN.
module axil_rw_scheduler
  import axil_sched_pkg::*;
#(
  parameter int unsigned HOLD_MAX       = HOLD_MAX_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_req,
  input  logic wr_last,
  output logic wr_gnt,
  input  logic wr_done,
  input  logic rd_req,
  input  logic rd_last,
  output logic rd_gnt,
  input  logic rd_done,
  output logic busy,
  output logic owner,
  output logic timeout_err
);

  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  // Handshake: a beat is taken in the cycle req && gnt; req must stay high until then.
  sched_state_e  state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_inc;
  logic          hold_cap;
  logic          wd_expired;

  assign hold_inc = (hold_q == HW'(HOLD_MAX)) ? hold_q : hold_q + HW'(1);
  assign hold_cap = (hold_q >= HW'(HOLD_MAX));

`ifdef AXIL_SCHED_TIMEOUT_EN
  logic timeout_q;
  logic in_wait;

  assign in_wait = (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);

  axil_sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (in_wait),
    .clr     (!in_wait),
    .expired (wd_expired)
  );

  // A done in the expiring cycle still counts; only a true timeout sets the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (wd_expired &&
                 !((state_q == S_WR_WAIT && wr_done) || (state_q == S_RD_WAIT && rd_done))) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_RD;
      hold_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        // On a tie the path that did not own the bus last wins.
        if (wr_req && (!rd_req || owner_q == OWN_RD)) begin
          state_d = S_WR_ISSUE;
          if (owner_q != OWN_WR) begin
            owner_d = OWN_WR;
            hold_d  = '0;
          end
        end else if (rd_req) begin
          state_d = S_RD_ISSUE;
          if (owner_q != OWN_RD) begin
            owner_d = OWN_RD;
            hold_d  = '0;
          end
        end
      end
      S_WR_ISSUE: begin
        if (wr_req) begin
          state_d = S_WR_WAIT;
          last_d  = wr_last;
          hold_d  = hold_inc;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (wr_done) begin
          if (last_q || (rd_req && hold_cap)) begin
            if (rd_req) begin
              state_d = S_RD_ISSUE;
              owner_d = OWN_RD;
              hold_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (wr_req) begin
            state_d = S_WR_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wd_expired) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end
      end
      S_RD_ISSUE: begin
        if (rd_req) begin
          state_d = S_RD_WAIT;
          last_d  = rd_last;
          hold_d  = hold_inc;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (rd_done) begin
          if (last_q || (wr_req && hold_cap)) begin
            if (wr_req) begin
              state_d = S_WR_ISSUE;
              owner_d = OWN_WR;
              hold_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (rd_req) begin
            state_d = S_RD_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wd_expired) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_gnt = (state_q == S_WR_ISSUE);
  assign rd_gnt = (state_q == S_RD_ISSUE);
  assign busy   = (state_q != S_IDLE);
  assign owner  = owner_q;

endmodule
